generic_sram_byte_en_rmw: RTL and testbench

- Downstream target of the Wishbone byte-enable SRAM bridge.
- Accepts the generic byte-enable SRAM client signals: addr, read_en, write_en, byte_en, write_data and read_data.
- Drives a word-only single-port SRAM macro with 1-cycle registered read latency.
- Partial-word writes are emulated by a read-modify-write FSM that fits inside the bridge's fixed two-cycle write window.

---
 rtl/generic_sram_rmw_pkg.sv | 30 +++
 rtl/generic_sram_rmw_proto_chk.sv | 50 +++++
 rtl/generic_sram_byte_en_rmw.sv | 121 ++++++++++++
 tb/tb_generic_sram_byte_en_rmw.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/generic_sram_rmw_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enable SRAM RMW adapter.
package generic_sram_rmw_pkg;

    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxLanes     = MaxDataWidth / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_MERGE = 2'd1,
        WR_HOLD   = 2'd2
    } rmw_state_e;

    // Operates on a max-width word; lanes at or above 'lanes' always keep the old value.
    function automatic logic [MaxDataWidth-1:0] byte_merge(
        input logic [MaxDataWidth-1:0] old_word,
        input logic [MaxDataWidth-1:0] new_word,
        input logic [MaxLanes-1:0]     be,
        input int unsigned             lanes
    );
        logic [MaxDataWidth-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (i < lanes && be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/generic_sram_rmw_proto_chk.sv
// Sticky protocol checker for the RMW adapter; only instantiated with
// GENERIC_SRAM_RMW_PROTO_CHECK_EN defined.
module generic_sram_rmw_proto_chk
    import generic_sram_rmw_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  rmw_state_e               state,
    input  logic                     read_en,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    output logic                     proto_err
);

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     err_q;
    logic                     viol;

    always_comb begin
        viol = read_en && write_en;
        if (state != IDLE) begin
            viol = viol || !write_en || (addr != addr_q);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && write_en) begin
                addr_q <= addr;
            end
            err_q <= err_q | viol;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rstn && viol) begin
            $error("generic_sram_rmw: protocol violation in state %s", state.name());
        end
    end
`endif

    assign proto_err = err_q;

endmodule

// File: rtl/generic_sram_byte_en_rmw.sv
// Byte-enable client to word-only SRAM adapter; partial writes use a 2-cycle RMW.
// Optional checker: define GENERIC_SRAM_RMW_PROTO_CHECK_EN to build proto_err logic.
module generic_sram_byte_en_rmw
    import generic_sram_rmw_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [ADDRESS_WIDTH-1:0]  addr,
    input  logic                      read_en,
    input  logic                      write_en,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      mem_ce,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      proto_err
);

    localparam int unsigned Lanes = DATA_WIDTH / 8;

    rmw_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [Lanes-1:0]       be_q;
    logic                   capture;

    logic [MaxDataWidth-1:0] old_ext, new_ext, merged_ext;
    logic [MaxLanes-1:0]     be_ext;
    logic                    unused_merged;

    assign mem_addr  = addr;
    assign read_data = mem_rdata;

    always_comb begin
        old_ext = '0;
        new_ext = '0;
        be_ext  = '0;
        old_ext[DATA_WIDTH-1:0] = mem_rdata;
        new_ext[DATA_WIDTH-1:0] = wdata_q;
        be_ext[Lanes-1:0]       = be_q;
        merged_ext = byte_merge(old_ext, new_ext, be_ext, Lanes);
    end

    assign unused_merged = ^merged_ext[MaxDataWidth-1:DATA_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                wdata_q <= write_data;
                be_q    <= byte_en;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (write_en) state_d = (&byte_en) ? WR_HOLD : RMW_MERGE;
            RMW_MERGE: state_d = IDLE;
            WR_HOLD:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Gated by rstn so an in-flight RMW write is dropped the instant reset asserts.
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = write_data;
        capture   = 1'b0;
        if (rstn) begin
            unique case (state_q)
                IDLE: begin
                    if (write_en) begin
                        mem_ce  = 1'b1;
                        mem_we  = &byte_en;
                        capture = ~&byte_en;
                    end else if (read_en) begin
                        mem_ce = 1'b1;
                    end
                end
                RMW_MERGE: begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = merged_ext[DATA_WIDTH-1:0];
                end
                WR_HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GENERIC_SRAM_RMW_PROTO_CHECK_EN
    generic_sram_rmw_proto_chk #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_proto_chk (
        .clk       (clk),
        .rstn      (rstn),
        .state     (state_q),
        .read_en   (read_en),
        .write_en  (write_en),
        .addr      (addr),
        .proto_err (proto_err)
    );
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_generic_sram_byte_en_rmw.sv
// Scoreboard bench: expected macro writes and read responses are queued by stimulus
// and checked by a negedge monitor against a behavioural SRAM macro.
module tb_generic_sram_byte_en_rmw;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] addr;
    logic          read_en;
    logic          write_en;
    logic [3:0]    byte_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          proto_err;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    logic          rd_sample;
    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] mem [0:1023];

    always #5 clk = ~clk;

    generic_sram_byte_en_rmw #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .addr      (addr),
        .read_en   (read_en),
        .write_en  (write_en),
        .byte_en   (byte_en),
        .write_data(write_data),
        .read_data (read_data),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .proto_err (proto_err)
    );

    // Behavioural single-port macro, 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_ce && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every macro write and every bridge read-sample pops the scoreboard.
    always @(negedge clk) begin
        if (mem_ce && mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_addr", {22'd0, mem_addr}, {22'd0, e.a});
                chk("wr_data", mem_wdata, e.d);
            end
        end
        if (rd_sample) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: data 0x%08h, none expected", read_data);
            end else begin
                logic [DW-1:0] r;
                r = exp_rd.pop_front();
                chk("rd_data", read_data, r);
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        read_en  = 1'b0;
        write_en = 1'b0;
        byte_en  = 4'h0;
    endtask

    // Two-cycle write window; exp is the word the macro must receive.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] be, input logic [DW-1:0] exp, input logic rd);
        exp_wr.push_back('{a: a, d: exp});
        @(posedge clk); #1;
        addr       = a;
        write_data = d;
        byte_en    = be;
        write_en   = 1'b1;
        read_en    = rd;
        @(negedge clk);
        chk("wr_c0_ce", {31'd0, mem_ce}, 32'd1);
        chk("wr_c0_we", {31'd0, mem_we}, {31'd0, (be == 4'hF)});
        @(posedge clk); #1;
        read_en = 1'b0;
        @(negedge clk);
        chk("wr_c1_ce", {31'd0, mem_ce}, {31'd0, (be != 4'hF)});
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        exp_rd.push_back(exp);
        @(posedge clk); #1;
        addr     = a;
        read_en  = 1'b1;
        write_en = 1'b0;
        @(negedge clk);
        chk("rd_ce", {31'd0, mem_ce}, 32'd1);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_sample = 1'b1;
        @(posedge clk); #1;
        rd_sample = 1'b0;
        read_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_perr;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rstn       = 1'b0;
        addr       = '0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        byte_en    = 4'h0;
        write_data = '0;
        rd_sample  = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ce", {31'd0, mem_ce}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_perr", {31'd0, proto_err}, 32'd0);
        rstn = 1'b1;

        // Full write then readback
        do_write(10'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
        do_read(10'h010, 32'hDEADBEEF);

        // Partial write merges lanes 0 and 2
        do_write(10'h020, 32'h11223344, 4'hF, 32'h11223344, 1'b0);
        do_write(10'h020, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, 1'b0);
        do_read(10'h020, 32'h11BB33DD);

        // byte_en=0 rewrites the old word unchanged
        do_write(10'h025, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0);
        do_write(10'h025, 32'h55555555, 4'h0, 32'hCAFEF00D, 1'b0);
        do_read(10'h025, 32'hCAFEF00D);

        // Back-to-back partial writes with no idle gap
        do_write(10'h030, 32'hA0A1A2A3, 4'hF, 32'hA0A1A2A3, 1'b0);
        do_write(10'h031, 32'hB0B1B2B3, 4'hF, 32'hB0B1B2B3, 1'b0);
        do_write(10'h030, 32'h0000BEEF, 4'h3, 32'hA0A1BEEF, 1'b0);
        do_write(10'h031, 32'hFACE0000, 4'hC, 32'hFACEB2B3, 1'b0);
        do_read(10'h030, 32'hA0A1BEEF);
        do_read(10'h031, 32'hFACEB2B3);

        // Reset during RMW_MERGE abandons the write
        do_write(10'h040, 32'h12345678, 4'hF, 32'h12345678, 1'b0);
        @(posedge clk); #1;
        addr       = 10'h040;
        write_data = 32'h000000FF;
        byte_en    = 4'h1;
        write_en   = 1'b1;
        read_en    = 1'b0;
        @(negedge clk);
        chk("rstmid_c0_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_we", {31'd0, mem_we}, 32'd0);
        chk("rstmid_ce", {31'd0, mem_ce}, 32'd0);
        write_en = 1'b0;
        byte_en  = 4'h0;
        @(negedge clk); #1;
        rstn = 1'b1;
        idle();
        do_read(10'h040, 32'h12345678);
        do_write(10'h041, 32'h01020304, 4'hF, 32'h01020304, 1'b0);
        do_read(10'h041, 32'h01020304);

        // Simultaneous read/write: write wins; proto_err per build
`ifdef GENERIC_SRAM_RMW_PROTO_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        do_write(10'h050, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 1'b1);
        idle();
        @(negedge clk);
        chk("perr_set", {31'd0, proto_err}, {31'd0, exp_perr});
        repeat (3) idle();
        @(negedge clk);
        chk("perr_sticky", {31'd0, proto_err}, {31'd0, exp_perr});
        do_read(10'h050, 32'h0BADF00D);

        for (int i = 0; i < 50 && (exp_wr.size() != 0 || exp_rd.size() != 0); i++)
            @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("rd_queue_empty", exp_rd.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
